// File: rtl/env_frame_scheduler_pkg.sv
// Shared types and constants for the world-update scheduling blocks.
package env_pkg;

  // Frame sequencer states, in the order a normal frame walks through them.
  typedef enum logic [2:0] {
    IDLE,
    ENV_START,
    ENV_WAIT,
    PHYS_START,
    PHYS_WAIT,
    SWAP
  } sched_state_t;

  // Default bound on how long any single done handshake may take.
  localparam int DEFAULT_TIMEOUT_CYCLES = 200000;

  // World geometry constants used by the environment update blocks.
  localparam int WORLD_BITS             = 10;
  localparam int MAX_POLYGONS_ON_SCREEN = 64;

endpackage

// File: rtl/env_frame_scheduler_handshake_watchdog.sv
// Cycle counter that flags a handshake which never produced its done pulse.
// One instance serves both wait states: the start states clear it, the wait
// states let it run.
module handshake_watchdog
  import env_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic enable,
  input  logic done,
  output logic timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Count wait cycles; hold at the terminal value so it can never wrap.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (enable && (wait_cnt != LAST)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // A done pulse on the terminal cycle beats the timeout.
  assign timeout = enable && !done && (wait_cnt == LAST);

endmodule

// File: rtl/env_frame_scheduler.sv
// Per-frame sequencer: on an accepted frame tick it runs the environment
// updater STEPS_PER_FRAME times, then the physics pass once, then flips the
// renderer buffer select. Dropped ticks are counted; a hung handshake parks
// the sequencer in IDLE with a sticky fault until reset.
module env_frame_scheduler
  import env_pkg::*;
#(
  parameter int STEPS_PER_FRAME = 1,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES,
  parameter int COUNT_BITS      = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  frame_in,
  input  logic                  pause_in,
  output logic                  env_start_out,
  input  logic                  env_done_in,
  output logic                  phys_start_out,
  input  logic                  phys_done_in,
  output logic                  buffer_sel_out,
  output logic                  frame_done_out,
  output logic                  busy_out,
  output logic [COUNT_BITS-1:0] overrun_count_out,
  output logic                  fault_out
);

  localparam int STEP_W = $clog2(STEPS_PER_FRAME + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS_PER_FRAME - 1);

  sched_state_t      state, state_nxt;
  logic [STEP_W-1:0] step_cnt, step_nxt;
  logic              fault_nxt;
  logic              wd_clear, wd_enable, wd_done, wd_timeout;
  logic              overrun;

  function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
    return (&v) ? v : v + COUNT_BITS'(1);
  endfunction

  // Watchdog controls come straight from the state register so the
  // next-state logic below only consumes the timeout result.
  assign wd_clear  = (state == ENV_START) || (state == PHYS_START);
  assign wd_enable = (state == ENV_WAIT)  || (state == PHYS_WAIT);
  assign wd_done   = ((state == ENV_WAIT)  && env_done_in) ||
                     ((state == PHYS_WAIT) && phys_done_in);

  handshake_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (wd_clear),
    .enable (wd_enable),
    .done   (wd_done),
    .timeout(wd_timeout)
  );

  // A tick that arrives while a frame is still in flight is dropped.
  assign overrun = frame_in && !pause_in && (state != IDLE);

  // Next-state, step and fault decisions.
  always_comb begin
    state_nxt = state;
    step_nxt  = step_cnt;
    fault_nxt = fault_out;
    case (state)
      IDLE: begin
        if (frame_in && !pause_in && !fault_out) begin
          state_nxt = ENV_START;
          step_nxt  = '0;
        end
      end
      ENV_START: state_nxt = ENV_WAIT;
      ENV_WAIT: begin
        if (env_done_in) begin
          if (step_cnt < LAST_STEP) begin
            step_nxt  = step_cnt + STEP_W'(1);
            state_nxt = ENV_START;
          end else begin
            state_nxt = PHYS_START;
          end
        end else if (wd_timeout) begin
          fault_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      PHYS_START: state_nxt = PHYS_WAIT;
      PHYS_WAIT: begin
        if (phys_done_in) begin
          state_nxt = SWAP;
        end else if (wd_timeout) begin
          fault_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, step counter and sticky fault.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      step_cnt  <= '0;
      fault_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      step_cnt  <= step_nxt;
      fault_out <= fault_nxt;
    end
  end

  // Moore outputs registered from the next state so each pulse lines up
  // exactly with the cycle the FSM spends in its state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      env_start_out  <= 1'b0;
      phys_start_out <= 1'b0;
      frame_done_out <= 1'b0;
      busy_out       <= 1'b0;
      buffer_sel_out <= 1'b0;
    end else begin
      env_start_out  <= (state_nxt == ENV_START);
      phys_start_out <= (state_nxt == PHYS_START);
      frame_done_out <= (state_nxt == SWAP);
      busy_out       <= (state_nxt != IDLE);
      if (state_nxt == SWAP) begin
        buffer_sel_out <= ~buffer_sel_out;
      end
    end
  end

  // Saturating count of dropped frame ticks.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      overrun_count_out <= '0;
    end else if (overrun) begin
      overrun_count_out <= sat_inc(overrun_count_out);
    end
  end

endmodule

// File: tb/tb_env_frame_scheduler.sv
// Directed bench for env_frame_scheduler. Instance A: one step per frame,
// 50-cycle timeout, 16-bit overrun count. Instance B: three steps per frame,
// 50-cycle timeout, 4-bit overrun count for saturation.
module tb_env_frame_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_frame, a_pause, a_env_done, a_phys_done;
  logic        a_env_start, a_phys_start, a_buf_sel, a_frame_done, a_busy, a_fault;
  logic [15:0] a_cnt;

  logic        b_rst, b_frame, b_pause, b_env_done, b_phys_done;
  logic        b_env_start, b_phys_start, b_buf_sel, b_frame_done, b_busy, b_fault;
  logic [3:0]  b_cnt;

  env_frame_scheduler #(
    .STEPS_PER_FRAME(1), .TIMEOUT_CYCLES(50), .COUNT_BITS(16)
  ) dut_a (
    .clk_in(clk), .rst_in(a_rst), .frame_in(a_frame), .pause_in(a_pause),
    .env_start_out(a_env_start), .env_done_in(a_env_done),
    .phys_start_out(a_phys_start), .phys_done_in(a_phys_done),
    .buffer_sel_out(a_buf_sel), .frame_done_out(a_frame_done),
    .busy_out(a_busy), .overrun_count_out(a_cnt), .fault_out(a_fault)
  );

  env_frame_scheduler #(
    .STEPS_PER_FRAME(3), .TIMEOUT_CYCLES(50), .COUNT_BITS(4)
  ) dut_b (
    .clk_in(clk), .rst_in(b_rst), .frame_in(b_frame), .pause_in(b_pause),
    .env_start_out(b_env_start), .env_done_in(b_env_done),
    .phys_start_out(b_phys_start), .phys_done_in(b_phys_done),
    .buffer_sel_out(b_buf_sel), .frame_done_out(b_frame_done),
    .busy_out(b_busy), .overrun_count_out(b_cnt), .fault_out(b_fault)
  );

  // Pulse tallies, taken mid-cycle.
  int a_env_n = 0, a_phys_n = 0, a_done_n = 0;
  int b_env_n = 0, b_phys_n = 0, b_done_n = 0;
  always @(negedge clk) begin
    if (a_env_start)  a_env_n++;
    if (a_phys_start) a_phys_n++;
    if (a_frame_done) a_done_n++;
    if (b_env_start)  b_env_n++;
    if (b_phys_start) b_phys_n++;
    if (b_frame_done) b_done_n++;
  end

  int   total = 0;
  int   bad   = 0;
  logic a_buf = 1'b0;
  logic b_buf = 1'b0;
  int   e0, p0, d0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Tick at t0, done in the cycle after each start: SWAP lands at t5.
  task automatic a_min_frame(input string tag);
    a_frame = 1'b1; cyc(); a_frame = 1'b0;
    chk({tag, "_env_start"}, a_env_start, 1);
    cyc(); a_env_done = 1'b1;
    cyc(); a_env_done = 1'b0;
    chk({tag, "_phys_start"}, a_phys_start, 1);
    cyc(); a_phys_done = 1'b1;
    cyc(); a_phys_done = 1'b0;
    a_buf = ~a_buf;
    chk({tag, "_frame_done"}, a_frame_done, 1);
    chk({tag, "_buf_sel"}, a_buf_sel, a_buf);
    cyc();
    chk({tag, "_busy_after"}, a_busy, 0);
  endtask

  initial begin
    a_rst = 1'b1; a_frame = 1'b0; a_pause = 1'b0; a_env_done = 1'b0; a_phys_done = 1'b0;
    b_rst = 1'b1; b_frame = 1'b0; b_pause = 1'b0; b_env_done = 1'b0; b_phys_done = 1'b0;
    repeat (3) cyc();
    a_rst = 1'b0; b_rst = 1'b0;

    // Reset state
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_buf", a_buf_sel, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_fault", a_fault, 0);
    chk("rst_a_pulses", {a_env_start, a_phys_start, a_frame_done}, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_cnt", b_cnt, 0);
    cyc();
    chk("idle_a_busy", a_busy, 0);

    // Nominal: dones 10 cycles after each start
    e0 = a_env_n; p0 = a_phys_n; d0 = a_done_n;
    a_frame = 1'b1; cyc(); a_frame = 1'b0;            // t1
    chk("nom_env_start", a_env_start, 1);
    chk("nom_busy", a_busy, 1);
    cyc();                                             // t2
    chk("nom_env_start_1cyc", a_env_start, 0);
    repeat (9) cyc();                                  // t11
    a_env_done = 1'b1;
    chk("nom_no_phys_early", a_phys_start, 0);
    cyc(); a_env_done = 1'b0;                          // t12
    chk("nom_phys_start_t12", a_phys_start, 1);
    repeat (10) cyc();                                 // t22
    a_phys_done = 1'b1;
    cyc(); a_phys_done = 1'b0;                         // t23
    a_buf = ~a_buf;
    chk("nom_frame_done", a_frame_done, 1);
    chk("nom_buf_sel", a_buf_sel, a_buf);
    chk("nom_busy_swap", a_busy, 1);
    cyc();                                             // t24
    chk("nom_busy_done", a_busy, 0);
    chk("nom_frame_done_1cyc", a_frame_done, 0);
    chk("nom_env_count", a_env_n - e0, 1);
    chk("nom_phys_count", a_phys_n - p0, 1);
    chk("nom_done_count", a_done_n - d0, 1);

    // Minimum latency
    a_min_frame("minlat");

    // Overrun: ticks every 8 cycles plus one during SWAP, dones take 20
    e0 = a_env_n; p0 = a_phys_n; d0 = a_done_n;
    for (int t = 0; t < 48; t++) begin
      a_frame     = ((t % 8) == 0) || (t == 43);
      a_env_done  = (t == 21);
      a_phys_done = (t == 42);
      if (t == 1)  chk("ovr_env_start", a_env_start, 1);
      if (t == 9)  chk("ovr_cnt_first", a_cnt, 1);
      if (t == 22) chk("ovr_phys_start", a_phys_start, 1);
      if (t == 43) chk("ovr_swap", a_frame_done, 1);
      cyc();
    end
    a_frame = 1'b0; a_env_done = 1'b0; a_phys_done = 1'b0;
    a_buf = ~a_buf;
    chk("ovr_cnt_final", a_cnt, 6);
    chk("ovr_busy", a_busy, 0);
    chk("ovr_buf", a_buf_sel, a_buf);
    chk("ovr_env_count", a_env_n - e0, 1);
    chk("ovr_phys_count", a_phys_n - p0, 1);

    // Stray phys_done in ENV_WAIT, then env_done on the exact timeout cycle
    a_frame = 1'b1; cyc(); a_frame = 1'b0;            // t1
    for (int t = 1; t <= 54; t++) begin
      a_phys_done = (t == 5) || (t == 53);
      a_env_done  = (t == 51);
      if (t == 7)  chk("stray_still_wait", {a_busy, a_phys_start, a_frame_done}, 3'b100);
      if (t == 52) begin
        chk("edge_phys_start", a_phys_start, 1);
        chk("edge_no_fault", a_fault, 0);
      end
      if (t == 54) begin
        a_buf = ~a_buf;
        chk("edge_frame_done", a_frame_done, 1);
        chk("edge_buf", a_buf_sel, a_buf);
      end
      cyc();
    end
    a_phys_done = 1'b0; a_env_done = 1'b0;

    // Pause suppresses ticks entirely
    e0 = a_env_n;
    a_pause = 1'b1; a_frame = 1'b1; cyc(); a_frame = 1'b0; cyc();
    a_pause = 1'b0;
    chk("pause_busy", a_busy, 0);
    chk("pause_cnt", a_cnt, 6);
    chk("pause_no_start", a_env_n - e0, 0);

    // Reset during PHYS_WAIT
    a_frame = 1'b1; cyc(); a_frame = 1'b0;            // t1
    cyc(); a_env_done = 1'b1;                         // t2
    cyc(); a_env_done = 1'b0;                         // t3
    chk("mid_phys_start", a_phys_start, 1);
    cyc(); cyc();                                     // t5 PHYS_WAIT
    a_rst = 1'b1;
    cyc(); a_rst = 1'b0;                              // t6
    a_buf = 1'b0;
    chk("midrst_busy", a_busy, 0);
    chk("midrst_buf", a_buf_sel, 0);
    chk("midrst_cnt", a_cnt, 0);
    chk("midrst_pulses", {a_env_start, a_phys_start, a_frame_done, a_fault}, 0);
    e0 = a_env_n; p0 = a_phys_n;
    repeat (3) cyc();
    chk("midrst_quiet", (a_env_n - e0) + (a_phys_n - p0), 0);
    a_min_frame("after_rst");

    // Timeout: env_done never arrives
    p0 = a_phys_n;
    a_frame = 1'b1; cyc(); a_frame = 1'b0;            // t1
    repeat (50) cyc();                                // t51
    chk("to_not_yet", a_fault, 0);
    chk("to_busy_t51", a_busy, 1);
    cyc();                                            // t52
    chk("to_fault", a_fault, 1);
    chk("to_idle", a_busy, 0);
    chk("to_buf_unchanged", a_buf_sel, a_buf);
    chk("to_no_phys", a_phys_n - p0, 0);
    e0 = a_env_n;
    a_frame = 1'b1; cyc(); a_frame = 1'b0; repeat (2) cyc();
    chk("fault_tick_ignored", a_env_n - e0, 0);
    chk("fault_tick_not_counted", a_cnt, 0);
    chk("fault_sticky", a_fault, 1);
    a_rst = 1'b1; cyc(); a_rst = 1'b0;
    a_buf = 1'b0;
    chk("fault_cleared", a_fault, 0);
    a_min_frame("after_fault");

    // Sub-stepping on B: three env steps, each only after the prior done
    e0 = b_env_n; p0 = b_phys_n; d0 = b_done_n;
    b_frame = 1'b1; cyc(); b_frame = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sub_env_start%0d", i), b_env_start, 1);
      for (int k = 0; k < 3; k++) begin
        cyc();
        chk($sformatf("sub_hold%0d_%0d", i, k), {b_env_start, b_phys_start}, 0);
      end
      b_env_done = 1'b1; cyc(); b_env_done = 1'b0;
    end
    chk("sub_phys_start", b_phys_start, 1);
    b_phys_done = 1'b1;                               // same cycle as start: ignored
    cyc(); b_phys_done = 1'b0;
    cyc();
    chk("sub_same_cycle_done_ignored", {b_busy, b_frame_done}, 2'b10);
    b_phys_done = 1'b1; cyc(); b_phys_done = 1'b0;
    b_buf = ~b_buf;
    chk("sub_frame_done", b_frame_done, 1);
    chk("sub_buf", b_buf_sel, b_buf);
    cyc();
    chk("sub_env_count", b_env_n - e0, 3);
    chk("sub_phys_count", b_phys_n - p0, 1);
    chk("sub_done_count", b_done_n - d0, 1);

    // Saturation on B's 4-bit counter: tick held high for 20 cycles
    e0 = b_env_n;
    b_frame = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (t == 14) chk("sat_cnt_mid", b_cnt, 13);
      cyc();
    end
    b_frame = 1'b0;
    chk("sat_cnt_max", b_cnt, 4'hF);
    cyc();
    chk("sat_env_once", b_env_n - e0, 1);
    b_rst = 1'b1; cyc(); b_rst = 1'b0;
    chk("sat_rst_cnt", b_cnt, 0);
    chk("sat_rst_buf", b_buf_sel, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
